// File: rtl/pcpu_pkg.sv
// Shared definitions for the pipeline front end.
// Holds the immediate-format encodings used by both the IF/ID buffer and the
// immediate generator, the supported major opcodes, the canonical NOP and the
// layout of one buffered fetch entry.
package pcpu_pkg;

  // Immediate-format select consumed by the immediate generator.
  typedef enum logic [2:0] {
    IMM_R = 3'b000,
    IMM_I = 3'b001,
    IMM_S = 3'b010,
    IMM_B = 3'b011,
    IMM_U = 3'b100,
    IMM_J = 3'b101
  } imm_mode_e;

  // Supported major opcodes (instr[6:0]).
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // addi x0, x0, 0 -- shown to decode whenever nothing is buffered.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // One buffered fetch beat. The decoded format and legality are captured at
  // enqueue time so the decode stage never re-derives them from instr.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [2:0]  imm_mode;
    logic        illegal;
  } entry_t;

endpackage

// File: rtl/imm_mode_decode.sv
// Combinational opcode classifier.
// Ports:
//   opcode   in  [6:0] major opcode of an instruction
//   imm_mode out [2:0] immediate-format select (IMM_R for unsupported opcodes)
//   illegal  out       opcode is outside the supported set
module imm_mode_decode
  import pcpu_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [2:0] imm_mode,
  output logic       illegal
);

  always_comb begin
    // NOTE: defaulting every output before the case means no path leaves a
    // value unassigned, so no latch is inferred.
    imm_mode = IMM_R;
    illegal  = 1'b0;
    case (opcode)
      OPC_OP:                                      imm_mode = IMM_R;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM:  imm_mode = IMM_I;
      OPC_STORE:                                   imm_mode = IMM_S;
      OPC_BRANCH:                                  imm_mode = IMM_B;
      OPC_LUI, OPC_AUIPC:                          imm_mode = IMM_U;
      OPC_JAL:                                     imm_mode = IMM_J;
      default: begin
        imm_mode = IMM_R;
        illegal  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/if_id_buffer.sv
// Fetch-to-decode skid FIFO.
// Buffers up to DEPTH fetched instructions between IF and ID, classifying the
// immediate format of each at enqueue time. Output is always the head entry;
// when empty, a NOP with the empty-value payload is presented.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   if_valid/if_pc/if_instr  fetch offer
//   if_ready                 space available (registered count only)
//   id_valid/id_pc/id_instr  head entry towards decode
//   id_imm_mode/id_illegal   stored classification of the head entry
//   id_ready                 decode consumes the head this cycle
//   flush                    drop everything buffered (redirect)
module if_id_buffer #(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = pcpu_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_instr,
  output logic        if_ready,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [2:0]  id_imm_mode,
  output logic        id_illegal,
  input  logic        id_ready,
  input  logic        flush
);

  import pcpu_pkg::entry_t;
  import pcpu_pkg::IMM_I;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];

  logic          enq, deq;
  logic [2:0]    dec_mode;
  logic          dec_illegal;
  entry_t        new_entry;
  entry_t        head;

  imm_mode_decode u_imm_mode_decode (
    .opcode   (if_instr[6:0]),
    .imm_mode (dec_mode),
    .illegal  (dec_illegal)
  );

  // Space check uses only registered state, so id_ready never reaches if_ready.
  assign if_ready = (count_q < CW'(DEPTH));
  assign id_valid = (count_q != '0);

  assign enq = if_valid && if_ready && !flush;
  assign deq = id_valid && id_ready && !flush;

  assign new_entry = '{pc: if_pc, instr: if_instr, imm_mode: dec_mode, illegal: dec_illegal};

  always_comb begin
    // NOTE: combinational next-state uses blocking '=' so later statements see
    // earlier updates; the flops below use '<=' so all state updates together.
    mem_d    = mem_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (enq) begin
        mem_d[wr_ptr_q] = new_entry;
        wr_ptr_d        = wr_ptr_q + PW'(1); // DEPTH is a power of two: wraps naturally
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({enq, deq})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;           // idle or simultaneous push/pop
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // NOTE: payload storage is deliberately not reset; count gates every read,
  // so stale contents are never visible and the array stays plain RAM/flops.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head        = mem_q[rd_ptr_q];
  assign id_pc       = id_valid ? head.pc       : 32'h0;
  assign id_instr    = id_valid ? head.instr    : NOP_INSTR;
  assign id_imm_mode = id_valid ? head.imm_mode : IMM_I;
  assign id_illegal  = id_valid ? head.illegal  : 1'b0;

endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer: directed scenarios plus a randomized
// run compared against a queue-based reference model.
module tb_if_id_buffer;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_pc = '0;
  logic [31:0] if_instr = '0;
  logic        if_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [2:0]  id_imm_mode;
  logic        id_illegal;
  logic        id_ready = 1'b0;
  logic        flush = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  if_id_buffer #(.DEPTH(DEPTH), .NOP_INSTR(32'h0000_0013)) dut (
    .clk         (clk),
    .rst         (rst),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .if_ready    (if_ready),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .id_instr    (id_instr),
    .id_imm_mode (id_imm_mode),
    .id_illegal  (id_illegal),
    .id_ready    (id_ready),
    .flush       (flush)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [2:0]  mode;
    logic        ill;
  } m_entry_t;

  m_entry_t mq[$];

  function automatic void classify(input logic [6:0] op, output logic [2:0] mode, output logic ill);
    ill = 1'b0;
    case (op)
      7'h33:                      mode = 3'd0;
      7'h13, 7'h03, 7'h67, 7'h73: mode = 3'd1;
      7'h23:                      mode = 3'd2;
      7'h63:                      mode = 3'd3;
      7'h37, 7'h17:               mode = 3'd4;
      7'h6F:                      mode = 3'd5;
      default: begin mode = 3'd0; ill = 1'b1; end
    endcase
  endfunction

  function automatic logic        m_ready(); return mq.size() < DEPTH;               endfunction
  function automatic logic        m_valid(); return mq.size() != 0;                  endfunction
  function automatic logic [31:0] m_pc();    return (mq.size() != 0) ? mq[0].pc    : 32'h0;        endfunction
  function automatic logic [31:0] m_instr(); return (mq.size() != 0) ? mq[0].instr : 32'h0000_0013; endfunction
  function automatic logic [2:0]  m_mode();  return (mq.size() != 0) ? mq[0].mode  : 3'b001;        endfunction
  function automatic logic        m_ill();   return (mq.size() != 0) ? mq[0].ill   : 1'b0;          endfunction

  // Apply one clock edge to both the model (from the inputs currently driven)
  // and the DUT, then land 1ns after the edge for sampling.
  task automatic cycle();
    m_entry_t e;
    bit       do_enq;
    if (rst || flush) begin
      mq.delete();
    end else begin
      do_enq = if_valid && (mq.size() < DEPTH);
      if (mq.size() != 0 && id_ready) void'(mq.pop_front());
      if (do_enq) begin
        e.pc    = if_pc;
        e.instr = if_instr;
        classify(if_instr[6:0], e.mode, e.ill);
        mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_valid = 1'b0; if_pc = '0; if_instr = '0; id_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [31:0] instr);
    if_valid = 1'b1; if_pc = pc; if_instr = instr;
  endtask

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    // reset must win over every other control in the same cycle
    rst = 1'b1; flush = 1'b1; id_ready = 1'b1; offer(32'h40, 32'h0000_0033);
    cycle();
    rst = 1'b0;
    idle_inputs();
    cycle();
    n_checks++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL reset_if_ready got=%0b exp=1", if_ready); end
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_id_valid got=%0b exp=0", id_valid); end
    n_checks++; if (id_instr !== 32'h0000_0013) begin n_fail++; $display("FAIL reset_id_instr got=%h exp=00000013", id_instr); end
    n_checks++; if (id_imm_mode !== 3'b001) begin n_fail++; $display("FAIL reset_imm_mode got=%b exp=001", id_imm_mode); end
    n_checks++; if (id_pc !== 32'h0) begin n_fail++; $display("FAIL reset_id_pc got=%h exp=0", id_pc); end
    n_checks++; if (id_illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got=%b exp=0", id_illegal); end
    // id_ready with an empty buffer is ignored
    id_ready = 1'b1;
    cycle();
    n_checks++; if (id_valid !== 1'b0 || if_ready !== 1'b1) begin n_fail++; $display("FAIL empty_deq valid=%0b ready=%0b exp 0/1", id_valid, if_ready); end
    idle_inputs();
  endtask

  task automatic test_stall_hold();
    do_reset();
    offer(32'h100, 32'h0050_0093);
    #1;
    // no same-cycle bypass: still empty before the edge
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL no_bypass id_valid got=%0b exp=0", id_valid); end
    cycle();
    if_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_instr !== 32'h0050_0093 || id_imm_mode !== 3'b001 || id_illegal !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold[%0d] got v=%0b pc=%h instr=%h mode=%b exp v=1 pc=100 instr=00500093 mode=001",
                 i, id_valid, id_pc, id_instr, id_imm_mode);
      end
      cycle();
    end
  endtask

  task automatic test_full();
    do_reset();
    offer(32'h200, 32'h00A0_0063); cycle();
    offer(32'h204, 32'h0000_006F); cycle();
    n_checks++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL full_if_ready got=%0b exp=0", if_ready); end
    offer(32'h208, 32'h0000_0037); cycle();   // must be ignored
    n_checks++; if (id_pc !== 32'h200 || if_ready !== 1'b0) begin n_fail++; $display("FAIL full_hold pc=%h ready=%0b exp pc=200 ready=0", id_pc, if_ready); end
    if_valid = 1'b0; id_ready = 1'b1;
    n_checks++; if (id_imm_mode !== 3'b011) begin n_fail++; $display("FAIL drain_b mode got=%b exp=011", id_imm_mode); end
    cycle();
    n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h204 || id_imm_mode !== 3'b101) begin n_fail++; $display("FAIL drain_j v=%0b pc=%h mode=%b exp v=1 pc=204 mode=101", id_valid, id_pc, id_imm_mode); end
    cycle();
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty id_valid got=%0b exp=0 (third beat leaked)", id_valid); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    do_reset();
    offer(32'h300, 32'h0050_0093); cycle();
    offer(32'h304, 32'h0011_2023); id_ready = 1'b1; cycle();
    n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h304 || id_imm_mode !== 3'b010 || if_ready !== 1'b1) begin
      n_fail++; $display("FAIL simul head v=%0b pc=%h mode=%b ready=%0b exp v=1 pc=304 mode=010 ready=1", id_valid, id_pc, id_imm_mode, if_ready);
    end
    if_valid = 1'b0; cycle();
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL simul_count id_valid got=%0b exp=0", id_valid); end
    idle_inputs();
  endtask

  task automatic test_flush();
    do_reset();
    offer(32'h400, 32'h0000_0033); cycle();
    offer(32'h404, 32'h0000_0013); cycle();
    flush = 1'b1; id_ready = 1'b1; offer(32'h500, 32'h0000_0017); cycle();
    flush = 1'b0; idle_inputs();
    n_checks++; if (id_valid !== 1'b0 || if_ready !== 1'b1) begin n_fail++; $display("FAIL flush v=%0b ready=%0b exp v=0 ready=1", id_valid, if_ready); end
    cycle();
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop id_valid got=%0b exp=0", id_valid); end
    // pointers restart at zero: a fresh beat comes out unharmed
    offer(32'h600, 32'h0000_0017); cycle(); if_valid = 1'b0;
    n_checks++; if (id_pc !== 32'h600 || id_imm_mode !== 3'b100) begin n_fail++; $display("FAIL post_flush pc=%h mode=%b exp pc=600 mode=100", id_pc, id_imm_mode); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    offer(32'h700, 32'h0000_0033); cycle();
    offer(32'h704, 32'h0000_0033); id_ready = 1'b1; rst = 1'b1; cycle();
    rst = 1'b0; idle_inputs();
    n_checks++; if (id_valid !== 1'b0 || if_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mid v=%0b ready=%0b exp v=0 ready=1", id_valid, if_ready); end
  endtask

  task automatic test_illegal();
    do_reset();
    offer(32'h800, 32'hFFFF_FFFF); cycle(); if_valid = 1'b0;
    n_checks++; if (id_illegal !== 1'b1 || id_imm_mode !== 3'b000 || id_instr !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL illegal ill=%0b mode=%b instr=%h exp ill=1 mode=000 instr=ffffffff", id_illegal, id_imm_mode, id_instr);
    end
  endtask

  task automatic test_random();
    logic [6:0] ops [0:10];
    logic [31:0] r;
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r        = $urandom();
      if_valid = ($urandom_range(0, 3) != 0);
      if_pc    = {$urandom_range(0, 65535), 2'b00} ;
      if_instr = (i % 7 == 3) ? r : {r[31:7], ops[$urandom_range(0, 10)]};
      id_ready = ($urandom_range(0, 2) != 0);
      flush    = ($urandom_range(0, 29) == 0);
      rst      = ($urandom_range(0, 99) == 0);
      cycle();
      n_checks++;
      if (if_ready !== m_ready() || id_valid !== m_valid() || id_pc !== m_pc() ||
          id_instr !== m_instr() || id_imm_mode !== m_mode() || id_illegal !== m_ill()) begin
        n_fail++;
        $display("FAIL random[%0d] got r=%0b v=%0b pc=%h i=%h m=%b il=%0b exp r=%0b v=%0b pc=%h i=%h m=%b il=%0b",
                 i, if_ready, id_valid, id_pc, id_instr, id_imm_mode, id_illegal,
                 m_ready(), m_valid(), m_pc(), m_instr(), m_mode(), m_ill());
      end
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_stall_hold();
    test_full();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_illegal();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
